// File: rtl/decoder_scan_nx.sv
// rtl/decoder_scan_nx.sv - registered one-hot decoder with enable and dwell-timed scan mode
//
// Purpose: SEL_W-to-2**SEL_W one-hot decoder. DECODE mode registers 1<<in with one
// cycle of latency. SCAN mode walks every channel in turn, holding each for DWELL
// cycles, starting from (and reloadable to) the index on `in`.
//
// Ports:
//   clk    in   1       clock, rising edge
//   rst    in   1       synchronous reset, active-high, highest priority
//   en     in   1       block enable; 0 drives the outputs idle
//   mode   in   1       0 = DECODE, 1 = SCAN
//   in     in   SEL_W   DECODE: channel select; SCAN: start/load index
//   load   in   1       SCAN only: restart the scan at `in`
//   out    out  NOUT    registered one-hot output, all-zero when idle
//   idx    out  SEL_W   registered binary index of the active line
//   valid  out  1       `out` carries a one-hot value
//   wrap   out  1       one-cycle pulse when a scan advance goes NOUT-1 -> 0
module decoder_scan_nx #(
    parameter int SEL_W = 2,
    parameter int DWELL = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      in,
    input  logic                  load,
    output logic [(1<<SEL_W)-1:0] out,
    output logic [SEL_W-1:0]      idx,
    output logic                  valid,
    output logic                  wrap
);

    localparam int NOUT  = 1 << SEL_W;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_SCAN   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [SEL_W-1:0]  r_idx;
    logic [SEL_W-1:0]  w_idx_nxt;
    logic [NOUT-1:0]   r_out;
    logic [NOUT-1:0]   w_out_nxt;
    logic              r_valid;
    logic              w_valid_nxt;
    logic              r_wrap;
    logic              w_wrap_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_out   <= w_out_nxt;
            r_valid <= w_valid_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    // Output values are computed for the state being entered so that every
    // output, including out, lands in a register on the same edge as the state.
    always_comb begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = '0;
        w_valid_nxt = 1'b0;
        w_wrap_nxt  = 1'b0;

        if (en) begin
            w_state_nxt = mode ? S_SCAN : S_DECODE;
        end

        case (w_state_nxt)
            S_DECODE: begin
                w_idx_nxt   = in;
                w_valid_nxt = 1'b1;
            end
            S_SCAN: begin
                w_valid_nxt = 1'b1;
                // Entry and load both restart at `in`; load outranks a due advance.
                if ((r_state != S_SCAN) || load) begin
                    w_idx_nxt = in;
                end else if (r_cnt == CNT_W'(DWELL - 1)) begin
                    w_idx_nxt  = r_idx + 1'b1;
                    w_wrap_nxt = (r_idx == {SEL_W{1'b1}});
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
            end
        endcase

        w_out_nxt = w_valid_nxt ? (NOUT'(1) << w_idx_nxt) : '0;
    end

    assign out   = r_out;
    assign idx   = r_idx;
    assign valid = r_valid;
    assign wrap  = r_wrap;

endmodule

// File: tb/tb_decoder_scan_nx.sv
// tb/tb_decoder_scan_nx.sv - scoreboard bench for decoder_scan_nx
module tb_decoder_scan_nx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: SEL_W=2, DWELL=3
    logic       rst, en, mode, load;
    logic [1:0] in_a;
    logic [3:0] out_a;
    logic [1:0] idx_a;
    logic       valid_a, wrap_a;

    // DUT B: SEL_W=3, DWELL=1
    logic       en_b, mode_b, load_b;
    logic [2:0] in_b;
    logic [7:0] out_b;
    logic [2:0] idx_b;
    logic       valid_b, wrap_b;

    decoder_scan_nx #(.SEL_W(2), .DWELL(3)) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .in(in_a), .load(load),
        .out(out_a), .idx(idx_a), .valid(valid_a), .wrap(wrap_a)
    );

    decoder_scan_nx #(.SEL_W(3), .DWELL(1)) u_dut_b (
        .clk(clk), .rst(rst), .en(en_b), .mode(mode_b), .in(in_b), .load(load_b),
        .out(out_b), .idx(idx_b), .valid(valid_b), .wrap(wrap_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [3:0] out;
        logic [1:0] idx;
        logic       valid;
        logic       wrap;
    } exp_t;

    exp_t sb_q[$];

    // Reference model of DUT A: 0 idle, 1 decode, 2 scan
    int         m_st  = 0;
    logic [1:0] m_idx = '0;
    int         m_cnt = 0;

    // Predict the result of the inputs now applied, push it, clock, then pop and compare.
    task automatic step(input string tag);
        exp_t e;
        e.wrap = 1'b0;
        if (rst) begin
            m_st = 0; m_idx = '0; m_cnt = 0; e.valid = 1'b0;
        end else if (!en) begin
            m_st = 0; m_cnt = 0; e.valid = 1'b0;
        end else if (!mode) begin
            m_st = 1; m_idx = in_a; m_cnt = 0; e.valid = 1'b1;
        end else begin
            if (m_st != 2 || load) begin
                m_idx = in_a; m_cnt = 0;
            end else if (m_cnt == 2) begin
                e.wrap = (m_idx == 2'd3);
                m_idx  = m_idx + 2'd1;
                m_cnt  = 0;
            end else begin
                m_cnt++;
            end
            m_st = 2; e.valid = 1'b1;
        end
        e.idx = m_idx;
        e.out = e.valid ? (4'b0001 << m_idx) : 4'b0000;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_val({tag, "_sb_underflow"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_val({tag, "_out"},   32'(out_a),   32'(e.out));
            check_val({tag, "_idx"},   32'(idx_a),   32'(e.idx));
            check_val({tag, "_valid"}, 32'(valid_a), 32'(e.valid));
            check_val({tag, "_wrap"},  32'(wrap_a),  32'(e.wrap));
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; mode = 1'b1; load = 1'b0; in_a = 2'd0;
        en_b = 1'b0; mode_b = 1'b0; load_b = 1'b0; in_b = 3'd0;

        // 1: reset with en=1, mode=1
        for (int i = 0; i < 2; i++) begin
            step("reset");
            check_val("reset_out_const", 32'(out_a), 32'h0);
            check_val("reset_wrap_const", 32'(wrap_a), 32'h0);
        end
        rst = 1'b0;

        // 2: decode sweep then disable
        mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_a = 2'(i);
            step("decode");
            check_val("decode_out_const", 32'(out_a), 32'(4'b0001 << i));
        end
        load = 1'b1; in_a = 2'd2;
        step("decode_load_ignored");
        load = 1'b0;
        en = 1'b0;
        step("disable");
        check_val("disable_out_const", 32'(out_a), 32'h0);
        check_val("disable_idx_held", 32'(idx_a), 32'd2);

        // 3: scan from 2, two full periods
        en = 1'b1; mode = 1'b1; in_a = 2'd2;
        for (int k = 0; k < 24; k++) begin
            step("scan_wrap");
            check_val("scan_out_const", 32'(out_a), 32'(4'b0001 << ((2 + k / 3) % 4)));
            check_val("scan_wrap_const", 32'(wrap_a),
                      32'((k % 3 == 0) && (((2 + k / 3) % 4) == 0)));
        end

        // 4: load collides with a due advance
        en = 1'b0;
        step("leave_scan");
        en = 1'b1; in_a = 2'd1;
        for (int k = 0; k < 3; k++) step("scan_to_collision");
        load = 1'b1; in_a = 2'd3;
        step("load_collision");
        check_val("load_out_const", 32'(out_a), 32'h8);
        check_val("load_wrap_const", 32'(wrap_a), 32'h0);
        load = 1'b0; in_a = 2'd0;
        for (int k = 0; k < 3; k++) step("after_load");
        check_val("after_load_out_const", 32'(out_a), 32'h1);
        check_val("after_load_wrap_const", 32'(wrap_a), 32'h1);

        // 5: reset mid-scan at idx 3, release into decode
        load = 1'b1; in_a = 2'd3;
        step("reload_3");
        load = 1'b0;
        rst = 1'b1;
        step("mid_reset");
        check_val("mid_reset_out_const", 32'(out_a), 32'h0);
        rst = 1'b0; mode = 1'b0; in_a = 2'd1;
        step("release_decode");
        check_val("release_out_const", 32'(out_a), 32'h2);

        // Random mix against the model
        for (int k = 0; k < 300; k++) begin
            rst  = ($urandom_range(0, 49) == 0);
            en   = ($urandom_range(0, 9) != 0);
            mode = ($urandom_range(0, 5) != 0) ? mode : ~mode;
            load = ($urandom_range(0, 7) == 0);
            in_a = 2'($urandom_range(0, 3));
            step("random");
            check_val("random_onehot0", 32'($onehot0(out_a)), 32'd1);
        end
        check_val("sb_empty", 32'(sb_q.size()), 32'd0);

        // 6: SEL_W=3, DWELL=1 scan from 0
        en = 1'b0; rst = 1'b0;
        en_b = 1'b1; mode_b = 1'b1; in_b = 3'd0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            check_val("b_out", 32'(out_b), 32'(8'h01 << (k % 8)));
            check_val("b_idx", 32'(idx_b), 32'(k % 8));
            check_val("b_wrap", 32'(wrap_b), 32'((k % 8 == 0) && (k > 0)));
            check_val("b_onehot", 32'($onehot(out_b)), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
